// File: rtl/spi_fetch_pkg.sv
// Shared definitions for the multi-channel SPI stream fetcher.
//   state_e      : transfer FSM states
//   DUMMY_BYTE   : filler byte clocked out while receiving
//   DEF_*        : default command/header bytes for the video (ch0) and audio (ch1) streams
//   CH_IDX_W     : width of a channel index (up to MAX_CH channels)
package spi_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_HDR,
    S_GAP,
    S_PAY,
    S_END,
    S_ERR
  } state_e;

  localparam logic [7:0]  DUMMY_BYTE  = 8'h00;

  localparam logic [7:0]  DEF_CMD_CH0 = 8'hFA;
  localparam logic [7:0]  DEF_CMD_CH1 = 8'hAA;
  localparam logic [7:0]  DEF_HDR_CH0 = 8'h05;
  localparam logic [7:0]  DEF_HDR_CH1 = 8'h55;

  localparam int unsigned MAX_CH      = 8;
  localparam int unsigned CH_IDX_W    = 3;

endpackage

// File: rtl/spi_stream_fetch_arb.sv
// Round-robin channel arbiter.
//   pending   : per-channel request vector
//   last      : index of the channel served most recently
//   grant     : one-hot grant (all zero when nothing pending)
//   grant_idx : index of the granted channel
//   valid     : at least one channel pending
// The search starts at the channel after 'last' and wraps, so the
// channel just served has lowest priority.
module rr_arbiter
  import spi_fetch_pkg::*;
#(
  parameter int unsigned N_CH = 2
) (
  input  logic [N_CH-1:0]     pending,
  input  logic [CH_IDX_W-1:0] last,
  output logic [N_CH-1:0]     grant,
  output logic [CH_IDX_W-1:0] grant_idx,
  output logic                valid
);

  localparam int unsigned CW = CH_IDX_W + 1;

  logic [MAX_CH-1:0] pend_ext;
  logic [CW-1:0]     cand;
  logic              found;

  always_comb begin
    pend_ext  = MAX_CH'(pending);
    cand      = '0;
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand = {1'b0, last} + CW'(k);
      if (cand >= CW'(N_CH)) begin
        cand = cand - CW'(N_CH);
      end
      if (!found && pend_ext[cand[CH_IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[CH_IDX_W-1:0];
      end
    end
    grant = found ? (N_CH'(1) << grant_idx) : '0;
    valid = found;
  end

endmodule

// File: rtl/spi_stream_fetch.sv
// Multi-channel SPI stream fetcher. Serves N_CH sink buffers round-robin
// over a single SPI byte link: command byte, header hunt with timeout and
// retry, then payload streaming into the selected sink.
//   CLK_40, reset_n        : clock, asynchronous active-low reset
//   start                  : mark all channels pending, clear err
//   ch_req[N_CH]           : per-channel refill request pulses
//   ch_full[N_CH]          : sink bank full, ends payload early
//   ch_wr, ch_wdata        : one-hot sink write strobe and byte
//   ch_done[N_CH]          : transfer-finished pulse
//   busy, err, err_ch      : status; err is sticky until start
//   cs_n, tx_valid/ready,
//   tx_byte, rx_valid,
//   rx_byte                : byte-level SPI master interface
module spi_stream_fetch
  import spi_fetch_pkg::*;
#(
  parameter int unsigned             N_CH        = 2,
  parameter int unsigned             LEN_W       = 16,
  parameter logic [N_CH*8-1:0]       CH_CMD      = {DEF_CMD_CH1, DEF_CMD_CH0},
  parameter logic [N_CH*8-1:0]       CH_HDR      = {DEF_HDR_CH1, DEF_HDR_CH0},
  parameter logic [N_CH*LEN_W-1:0]   CH_LEN      = {16'd512, 16'd9600},
  parameter int unsigned             HDR_TIMEOUT = 64,
  parameter int unsigned             MAX_RETRY   = 3
) (
  input  logic              CLK_40,
  input  logic              reset_n,
  input  logic              start,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH-1:0]   ch_full,
  output logic [N_CH-1:0]   ch_wr,
  output logic [7:0]        ch_wdata,
  output logic [N_CH-1:0]   ch_done,
  output logic              busy,
  output logic              err,
  output logic [2:0]        err_ch,
  output logic              cs_n,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_byte,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte
);

  localparam int unsigned RETRY_W = 8;

  // Per-channel constants unpacked into fixed-size tables indexed by sel.
  logic [7:0]       cmd_tab [MAX_CH];
  logic [7:0]       hdr_tab [MAX_CH];
  logic [LEN_W-1:0] len_tab [MAX_CH];

  for (genvar g = 0; g < MAX_CH; g++) begin : g_tab
    if (g < N_CH) begin : g_used
      assign cmd_tab[g] = CH_CMD[g*8 +: 8];
      assign hdr_tab[g] = CH_HDR[g*8 +: 8];
      assign len_tab[g] = CH_LEN[g*LEN_W +: LEN_W];
    end else begin : g_unused
      assign cmd_tab[g] = DUMMY_BYTE;
      assign hdr_tab[g] = DUMMY_BYTE;
      assign len_tab[g] = '0;
    end
  end

  logic [MAX_CH-1:0] full_ext;
  assign full_ext = MAX_CH'(ch_full);

  state_e               state_q,    state_d;
  logic [CH_IDX_W-1:0]  sel_q,      sel_d;
  logic [N_CH-1:0]      sel_oh_q,   sel_oh_d;
  logic [CH_IDX_W-1:0]  last_q,     last_d;
  logic [LEN_W-1:0]     cnt_q,      cnt_d;
  logic [RETRY_W-1:0]   retry_q,    retry_d;
  logic [N_CH-1:0]      pending_q,  pending_d;
  logic                 err_q,      err_d;
  logic [2:0]           err_ch_q,   err_ch_d;
  logic                 cs_n_q,     cs_n_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_byte_q,  tx_byte_d;
  logic [N_CH-1:0]      ch_wr_q,    ch_wr_d;
  logic [7:0]           ch_wdata_q, ch_wdata_d;
  logic [N_CH-1:0]      ch_done_q,  ch_done_d;
  logic                 busy_q,     busy_d;

  logic [N_CH-1:0]      arb_grant;
  logic [CH_IDX_W-1:0]  arb_idx;
  logic                 arb_valid;
  logic [N_CH-1:0]      pend_clr;
  logic [LEN_W-1:0]     cnt_inc;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .pending   (pending_q),
    .last      (last_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    sel_oh_d   = sel_oh_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    err_d      = err_q & ~start;
    err_ch_d   = err_ch_q;
    ch_wr_d    = '0;
    ch_wdata_d = ch_wdata_q;
    pend_clr   = '0;
    cnt_inc    = cnt_q + LEN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          state_d  = S_CMD;
          sel_d    = arb_idx;
          sel_oh_d = arb_grant;
          last_d   = arb_idx;
          retry_d  = '0;
          cnt_d    = '0;
          // The request is consumed when the channel is granted, so a
          // refill request arriving during the transfer queues a further
          // pass instead of being absorbed by the one in progress.
          pend_clr = arb_grant;
        end
      end
      S_CMD: begin
        if (tx_valid_q && tx_ready) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        if (rx_valid) begin
          if (rx_byte == hdr_tab[sel_q]) begin
            state_d = S_PAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == LEN_W'(HDR_TIMEOUT)) begin
              if (retry_q < RETRY_W'(MAX_RETRY)) begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = S_GAP;
              end else begin
                state_d = S_ERR;
              end
            end
          end
        end
      end
      S_GAP: begin
        state_d = S_CMD;
      end
      S_PAY: begin
        if (rx_valid) begin
          if (full_ext[sel_q]) begin
            state_d = S_END;
          end else begin
            ch_wr_d    = sel_oh_q;
            ch_wdata_d = rx_byte;
            cnt_d      = cnt_inc;
            if (cnt_inc == len_tab[sel_q]) begin
              state_d = S_END;
            end
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_ERR) begin
      err_d    = 1'b1;
      err_ch_d = sel_q;
    end

    // Sets win over a same-cycle clear.
    pending_d = (pending_q & ~pend_clr) | ch_req | {N_CH{start}};

    // Outputs are decoded from the next state so the registered copies
    // line up with state_q.
    cs_n_d     = 1'b1;
    tx_valid_d = 1'b0;
    tx_byte_d  = DUMMY_BYTE;
    ch_done_d  = '0;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_CMD: begin
        cs_n_d     = 1'b0;
        tx_valid_d = 1'b1;
        tx_byte_d  = cmd_tab[sel_d];
      end
      S_HDR, S_PAY: begin
        cs_n_d     = 1'b0;
        tx_valid_d = 1'b1;
      end
      S_END: begin
        ch_done_d = sel_oh_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      sel_oh_q   <= '0;
      last_q     <= CH_IDX_W'(N_CH - 1);
      cnt_q      <= '0;
      retry_q    <= '0;
      pending_q  <= '0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
      cs_n_q     <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      ch_wr_q    <= '0;
      ch_wdata_q <= '0;
      ch_done_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sel_oh_q   <= sel_oh_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      err_ch_q   <= err_ch_d;
      cs_n_q     <= cs_n_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      ch_wr_q    <= ch_wr_d;
      ch_wdata_q <= ch_wdata_d;
      ch_done_q  <= ch_done_d;
      busy_q     <= busy_d;
    end
  end

  assign ch_wr    = ch_wr_q;
  assign ch_wdata = ch_wdata_q;
  assign ch_done  = ch_done_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign err_ch   = err_ch_q;
  assign cs_n     = cs_n_q;
  assign tx_valid = tx_valid_q;
  assign tx_byte  = tx_byte_q;

endmodule
